param_lifo: RTL and testbench
=============================

PARAM_LIFO -- requirements
Module: param_lifo

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 8, data word width (1..64).
- DEPTH, default 8, number of stack entries (2..256).
- AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
- AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-002 Ports SHALL be (CW = ceil(log2(DEPTH+1))):
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wn  in  1  push request.
- rn  in  1  pop request.
- datain  in  DATA_W  push data.
- dataout  out  DATA_W  popped word, registered.
- dout_valid  out  1  one-cycle pulse, dataout updated by a pop.
- top  out  DATA_W  combinational peek of current top entry, 0 when empty.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky push-when-full error.
- underflow  out  1  sticky pop-when-empty error.
- err_clr  in  1  synchronous clear of overflow/underflow.

Function
REQ-003 Storage SHALL be DEPTH x DATA_W, indexed by count; the top entry is mem[count-1]; memory contents are not reset.
REQ-004 Push only (wn=1, rn=0, !full) SHALL write datain to mem[count] and increment count; the new word appears on top in the next cycle.
REQ-005 Pop only (rn=1, wn=0, !empty) SHALL load dataout with mem[count-1], pulse dout_valid the next cycle, and decrement count; latency is 1 cycle.
REQ-006 Push+pop with !empty SHALL load dataout with the current top and pulse dout_valid, write datain to mem[count-1], and leave count unchanged; this holds also when full, with no overflow.
REQ-007 Push+pop with empty SHALL perform the push only (count 0->1), leave dataout unchanged, keep dout_valid low, and set underflow.
REQ-008 Push when full without pop SHALL be ignored (memory, count unchanged) and set overflow.
REQ-009 Pop when empty without push SHALL be ignored (dataout held, dout_valid low) and set underflow.
REQ-010 dataout SHALL hold its value between pops; dout_valid SHALL be high exactly one cycle per accepted pop.
REQ-011 full, empty, almost_full, almost_empty SHALL be combinational decodes of the registered count.
REQ-012 count SHALL never exceed DEPTH or wrap below 0.
REQ-013 err_clr SHALL clear both sticky flags; an error event in the same cycle as err_clr SHALL win (flag set).

Reset
REQ-014 reset_n low SHALL asynchronously force count=0, dataout=0, dout_valid=0, overflow=0, underflow=0; hence empty=1, full=0, top=0.
REQ-015 Deassertion SHALL be synchronised externally; the first operation is accepted on the first rising edge with reset_n high.
REQ-016 Reset asserted mid-operation SHALL discard any in-flight push/pop; the stack is logically empty afterwards.

Configuration
REQ-017 Macro PARAM_LIFO_ERR_FLAGS_EN defined SHALL implement overflow/underflow/err_clr per REQ-007..009, 013.
REQ-018 Without PARAM_LIFO_ERR_FLAGS_EN, overflow and underflow SHALL be tied 0 and err_clr ignored; all other behaviour is identical.

Verification
REQ-019 The bench SHALL cover these scenarios (DATA_W=8, DEPTH=8, AF_LEVEL=7, AE_LEVEL=1):
- Reset, push 0x11..0x18 -> count=8, full=1, almost_full=1 at count 7, top=0x18.
- Full stack, pop 8 times -> dataout 0x18..0x11, each with a dout_valid pulse 1 cycle after rn, then empty=1, top=0.
- Count 3 (top 0x33), push+pop with datain=0xAA -> dataout=0x33, count=3, top=0xAA; repeat when full -> overflow stays 0.
- Full stack, push 0x99 -> count=8, top unchanged, overflow=1; then err_clr -> overflow=0.
- Empty stack, pop -> underflow=1, dout_valid=0; push+pop with datain=0x5C -> count=1, top=0x5C.
- Count 5, assert reset_n low between clock edges -> count=0 and dataout=0 immediately, without a clock edge; rebuild with the macro undefined -> the REQ-017 error cases give overflow=underflow=0.

Source files
------------

// File: rtl/param_lifo.sv
// param_lifo -- parameterised synchronous LIFO (stack) with occupancy flags.
//
// Optional feature macro: PARAM_LIFO_ERR_FLAGS_EN
//   defined   : overflow/underflow are sticky error flags, cleared by err_clr
//   undefined : overflow/underflow tied 0, err_clr ignored
//
// Ports
//   clk           rising-edge clock for all state
//   reset_n       asynchronous active-low reset
//   wn            push request
//   rn            pop request
//   datain        push data
//   dataout       registered popped word, held between pops
//   dout_valid    one-cycle pulse when dataout was loaded by a pop
//   top           combinational peek at the top entry (0 when empty)
//   count         current occupancy (0..DEPTH)
//   full/empty    count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   overflow      sticky push-when-full error
//   underflow     sticky pop-when-empty error
//   err_clr       synchronous clear of overflow/underflow
//
// Handshake: wn/rn are requests sampled on every rising edge with no ready
// back-pressure; acceptance is observable through count and the error flags.
// A request that cannot be honoured is dropped. dout_valid is a one-cycle
// valid strobe qualifying dataout, there is no ready on the output side.

module param_lifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wn,
  input  logic              rn,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     wr_idx;   // slot above the top: mem[count]
  logic [AW-1:0]     top_idx;  // current top: mem[count-1]
  logic              do_push;
  logic              do_pop;
  logic              do_swap;

  assign wr_idx  = AW'(count_q);
  assign top_idx = AW'(count_q - CW'(1));

  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign top          = empty ? '0 : mem[top_idx];

  // Push+pop on a non-empty stack replaces the top in place (count unchanged,
  // legal even when full). Push+pop on an empty stack degrades to a push.
  assign do_swap = wn && rn && !empty;
  assign do_push = wn && !full && (!rn || empty);
  assign do_pop  = rn && !wn && !empty;

  // Storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (do_push) begin
        mem[wr_idx] <= datain;
      end else if (do_swap) begin
        mem[top_idx] <= datain;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= do_pop || do_swap;
      if (do_pop || do_swap) begin
        dataout <= mem[top_idx];
      end
      if (do_push) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

`ifdef PARAM_LIFO_ERR_FLAGS_EN
  logic ovf_event;
  logic udf_event;

  // Any pop request on an empty stack is an underflow, including push+pop.
  assign ovf_event = wn && !rn && full;
  assign udf_event = rn && empty;

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (udf_event) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_lifo.sv
module tb_param_lifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CW     = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              wn;
  logic              rn;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;
  logic              dout_valid;
  logic [DATA_W-1:0] top;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  param_lifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(7),
    .AE_LEVEL(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wn          (wn),
    .rn          (rn),
    .datain      (datain),
    .dataout     (dataout),
    .dout_valid  (dout_valid),
    .top         (top),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_stk[$];
  logic [DATA_W-1:0] exp_dout;
  logic              m_ovf;
  logic              m_udf;
  int                n_checks = 0;
  int                n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_top();
    if (m_stk.size() == 0) return '0;
    return m_stk[m_stk.size()-1];
  endfunction

  // output monitor: every dout_valid pulse consumes one expected word
  always @(negedge clk) begin
    if (reset_n && dout_valid) begin
      if (exp_q.size() == 0) begin
        check("dout_valid_unexpected", 1, 0);
      end else begin
        check("dataout_sb", dataout, exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_count"}, count, m_stk.size());
    check({tag, "_top"}, top, m_top());
    check({tag, "_full"}, full, m_stk.size() == DEPTH);
    check({tag, "_empty"}, empty, m_stk.size() == 0);
    check({tag, "_afull"}, almost_full, m_stk.size() >= 7);
    check({tag, "_aempty"}, almost_empty, m_stk.size() <= 1);
    check({tag, "_dataout"}, dataout, exp_dout);
`ifdef PARAM_LIFO_ERR_FLAGS_EN
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_udf"}, underflow, m_udf);
`else
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_udf"}, underflow, 1'b0);
`endif
  endtask

  // driver: one operation per clock, model updated from the request
  task automatic do_op(input logic w, input logic r, input logic [DATA_W-1:0] d,
                       input logic clr);
    logic exp_valid;
    logic ovf_ev;
    logic udf_ev;
    exp_valid = 1'b0;
    ovf_ev    = 1'b0;
    udf_ev    = 1'b0;
    if (w && r) begin
      if (m_stk.size() > 0) begin
        exp_dout = m_top();
        exp_q.push_back(exp_dout);
        m_stk[m_stk.size()-1] = d;
        exp_valid = 1'b1;
      end else begin
        m_stk.push_back(d);
        udf_ev = 1'b1;
      end
    end else if (w) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(d);
      else ovf_ev = 1'b1;
    end else if (r) begin
      if (m_stk.size() > 0) begin
        exp_dout = m_stk.pop_back();
        exp_q.push_back(exp_dout);
        exp_valid = 1'b1;
      end else begin
        udf_ev = 1'b1;
      end
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (udf_ev) m_udf = 1'b1;
    else if (clr) m_udf = 1'b0;

    @(negedge clk);
    wn = w; rn = r; datain = d; err_clr = clr;
    @(posedge clk);
    #1;
    wn = 1'b0; rn = 1'b0; err_clr = 1'b0;
    check("dout_valid", dout_valid, exp_valid);
    check_state("op");
  endtask

  task automatic model_reset();
    m_stk.delete();
    exp_dout = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  initial begin
    wn = 1'b0; rn = 1'b0; datain = '0; err_clr = 1'b0;
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_top", top, 0);
    check("rst_dataout", dataout, 0);
    check("rst_dv", dout_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // fill 0x11..0x18
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1, 0, 8'h11 + 8'(i), 0);
      if (i == 6) check("s1_afull_at7", almost_full, 1);
    end
    check("s1_full", full, 1);
    check("s1_top", top, 8'h18);

    // drain: 0x18..0x11
    for (int i = 0; i < DEPTH; i++) begin
      do_op(0, 1, 8'h00, 0);
      check("s2_dout", dataout, 8'h18 - 8'(i));
    end
    check("s2_empty", empty, 1);
    check("s2_top", top, 0);

    // push+pop at count 3, then at full
    do_op(1, 0, 8'h31, 0);
    do_op(1, 0, 8'h32, 0);
    do_op(1, 0, 8'h33, 0);
    do_op(1, 1, 8'hAA, 0);
    check("s3_dout", dataout, 8'h33);
    check("s3_top", top, 8'hAA);
    for (int i = 0; i < 5; i++) do_op(1, 0, 8'h40 + 8'(i), 0);
    do_op(1, 1, 8'hBB, 0);
    check("s3_full_swap_dout", dataout, 8'h44);
    check("s3_full_swap_ovf", overflow, 0);

    // overflow, error-vs-clear priority, then clear
    do_op(1, 0, 8'h99, 0);
    check("s4_top_unchanged", top, 8'hBB);
    do_op(1, 0, 8'h98, 1);
    do_op(0, 0, 8'h00, 1);

    // drain, underflow, push+pop on empty
    for (int i = 0; i < DEPTH; i++) do_op(0, 1, 8'h00, 0);
    do_op(0, 1, 8'h00, 0);
    do_op(1, 1, 8'h5C, 0);
    check("s5_top", top, 8'h5C);
    do_op(0, 0, 8'h00, 1);

    // random mix
    for (int i = 0; i < 80; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    end

    // asynchronous reset mid-operation at count 5
    while (m_stk.size() > 0) do_op(0, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) do_op(1, 0, 8'h60 + 8'(i), 0);
    do_op(0, 1, 8'h00, 0);
    do_op(1, 0, 8'h70, 0);
    @(negedge clk);
    #1;
    wn = 1'b1; datain = 8'h77;
    #1;
    reset_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_dataout", dataout, 0);
    check("async_empty", empty, 1);
    check("async_top", top, 0);
    wn = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    do_op(1, 0, 8'h21, 0);
    do_op(0, 1, 8'h00, 0);

    @(negedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
